mvu_pe_acc_ctrl: RTL

MVU_PE_ACC_CTRL -- requirements
Module: mvu_pe_acc_ctrl

---
 rtl/mvu_pe_acc_ctrl_pkg.sv | 17 +
 rtl/mvu_pe_fold_cnt.sv | 26 ++
 rtl/mvu_pe_acc_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/mvu_pe_acc_ctrl_pkg.sv
// Shared MVAU definitions for the PE accumulator: default widths, the accumulator
// FSM states and the signed saturation limits used when MVU_PE_ACC_SAT_EN is defined.
package mvu_pe_acc_ctrl_pkg;

  localparam int unsigned TDSTI_DEF = 16;
  localparam int unsigned SF_DEF    = 4;

  // Limits held at 64-bit width; users right-shift them down to their word length.
  localparam logic [63:0] SAT_POS_LIM = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_NEG_LIM = 64'h8000_0000_0000_0000;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

endpackage

// File: rtl/mvu_pe_fold_cnt.sv
// Synapse-fold beat counter: counts accepted beats 0..SF-1 and flags the last one.
module mvu_pe_fold_cnt
  import mvu_pe_acc_ctrl_pkg::*;
#(
  parameter int unsigned SF = SF_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic               wrap,
  output logic [$clog2(SF):0] cnt
);

  localparam int unsigned CW = $clog2(SF) + 1;

  assign wrap = (cnt == CW'(SF - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mvu_pe_acc_ctrl.sv
// PE accumulator controller: sums SF adder-tree beats per output with a valid/ready
// handshake on both sides. Define MVU_PE_ACC_SAT_EN for signed saturating accumulation.
module mvu_pe_acc_ctrl
  import mvu_pe_acc_ctrl_pkg::*;
#(
  parameter int unsigned TDstI = TDSTI_DEF,
  parameter int unsigned SF    = SF_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_v,
  input  logic [TDstI-1:0]   in_add,
  output logic               in_rdy,
  output logic               out_v,
  output logic [TDstI-1:0]   out_acc,
  input  logic               out_rdy,
  output logic [$clog2(SF):0] sf_cnt
);

  acc_state_e       state;
  logic [TDstI-1:0] acc;
  logic [TDstI-1:0] add_res;
  logic             accept;
  logic             wrap;

  // In HOLD the input side follows out_rdy so a consume and a new first beat coincide.
  assign in_rdy  = (state == ACC) | out_rdy;
  assign accept  = in_v & in_rdy;
  assign out_acc = acc;

  mvu_pe_fold_cnt #(
    .SF (SF)
  ) u_fold_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .wrap (wrap),
    .cnt  (sf_cnt)
  );

`ifdef MVU_PE_ACC_SAT_EN
  localparam logic [TDstI-1:0] SAT_HI = TDstI'(SAT_POS_LIM >> (64 - TDstI));
  localparam logic [TDstI-1:0] SAT_LO = TDstI'(SAT_NEG_LIM >> (64 - TDstI));

  logic [TDstI-1:0] sum;
  logic             ovf;

  // Overflow only when both operands share a sign that the sum does not.
  always_comb begin
    sum     = acc + in_add;
    ovf     = (acc[TDstI-1] == in_add[TDstI-1]) && (sum[TDstI-1] != acc[TDstI-1]);
    add_res = sum;
    if (ovf) begin
      add_res = acc[TDstI-1] ? SAT_LO : SAT_HI;
    end
  end
`else
  always_comb begin
    add_res = acc + in_add;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      out_v <= 1'b0;
    end else begin
      if (accept) begin
        acc <= (sf_cnt == '0) ? in_add : add_res;
      end
      case (state)
        ACC: begin
          if (accept && wrap) begin
            state <= HOLD;
            out_v <= 1'b1;
          end
        end
        HOLD: begin
          if (out_rdy) begin
            // With SF=1 the beat taken on consume completes a fold on its own.
            if (accept && wrap) begin
              state <= HOLD;
              out_v <= 1'b1;
            end else begin
              state <= ACC;
              out_v <= 1'b0;
            end
          end
        end
        default: begin
          state <= ACC;
          out_v <= 1'b0;
        end
      endcase
    end
  end

endmodule
